// File: rtl/bpred_update_queue_pkg.sv
// Fetch-unit types shared by the branch-predictor update path.
// Holds address/index widths, the branch result and BTB entry layouts,
// the update-queue entry, and the index/saturation helpers.
package bpred_update_queue_pkg;

  localparam int ADDR_WIDTH                      = 32;
  localparam int INSN_ADDR_BIT_WIDTH             = 2;
  localparam int PHT_ENTRY_NUM_BIT_WIDTH         = 10;
  localparam int PHT_ENTRY_WIDTH                 = 2;
  localparam int PHT_ENTRY_MAX                   = 3;
  localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 12;
  localparam int BTB_ENTRY_NUM_BIT_WIDTH         = 9;
  localparam int BTB_TAG_WIDTH                   = 6;
  localparam int BTB_ADDR_WIDTH                  = ADDR_WIDTH - INSN_ADDR_BIT_WIDTH;
  localparam int BTB_QUEUE_SIZE                  = 32;

  typedef logic [ADDR_WIDTH-1:0]                      PC_Path;
  typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;
  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]         PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0]                 PHT_EntryPath;
  typedef logic [BTB_ENTRY_NUM_BIT_WIDTH-1:0]         BTB_IndexPath;
  typedef logic [BTB_TAG_WIDTH-1:0]                   BTB_TagPath;
  typedef logic [BTB_ADDR_WIDTH-1:0]                  BTB_AddrPath;

  typedef struct packed {
    logic                   valid;
    PC_Path                 brAddr;
    BranchGlobalHistoryPath globalHistory;
    PHT_EntryPath           phtPrevValue;
    logic                   isCondBr;
    logic                   execTaken;
    PC_Path                 nextAddr;
  } BranchResult;

  typedef struct packed {
    logic        valid;
    BTB_TagPath  tag;
    BTB_AddrPath data;
    logic        isCondBr;
  } BTB_Entry;

  typedef struct packed {
    logic         phtWE;
    PHT_IndexPath phtWA;
    PHT_EntryPath phtWV;
    logic         btbWE;
    BTB_IndexPath btbWA;
    BTB_Entry     btbWV;
  } BranchUpdateQueueEntry;

  // History is cast to the PHT index width: truncated if wider, zero-extended if narrower.
  function automatic PHT_IndexPath ToPHT_Index(PC_Path addr, BranchGlobalHistoryPath hist);
    PHT_IndexPath h;
    h = PHT_IndexPath'(hist);
    return addr[PHT_ENTRY_NUM_BIT_WIDTH+INSN_ADDR_BIT_WIDTH-1:INSN_ADDR_BIT_WIDTH] ^ h;
  endfunction

  function automatic PHT_EntryPath SaturatePHT(PHT_EntryPath v, logic taken);
    if (taken) return (v == PHT_EntryPath'(PHT_ENTRY_MAX)) ? v : v + 1'b1;
    else       return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic BTB_IndexPath ToBTB_Index(PC_Path addr);
    return addr[BTB_ENTRY_NUM_BIT_WIDTH+INSN_ADDR_BIT_WIDTH-1:INSN_ADDR_BIT_WIDTH];
  endfunction

  function automatic BTB_TagPath ToBTB_Tag(PC_Path addr);
    return addr[BTB_TAG_WIDTH+BTB_ENTRY_NUM_BIT_WIDTH+INSN_ADDR_BIT_WIDTH-1:
                BTB_ENTRY_NUM_BIT_WIDTH+INSN_ADDR_BIT_WIDTH];
  endfunction

  function automatic BTB_AddrPath ToBTB_Addr(PC_Path addr);
    return addr[ADDR_WIDTH-1:INSN_ADDR_BIT_WIDTH];
  endfunction

endpackage

// File: rtl/bpred_update_queue_circular_queue_pointer.sv
// Head/tail/count bookkeeping for a power-of-two circular queue.
// Ports: clk/rst (sync, active-high), push/pop strobes (caller guarantees
// no push when full and no pop when empty), head_o/tail_o indices,
// count_o occupancy, full_o/empty_o flags derived from the registered count.
module circular_queue_pointer #(
  parameter int SIZE    = 32,
  parameter int INDEX_W = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [INDEX_W-1:0] head_o,
  output logic [INDEX_W-1:0] tail_o,
  output logic [INDEX_W:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [INDEX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [INDEX_W:0]   count_q, count_d;

  // Pointers are exactly INDEX_W bits so they wrap SIZE-1 -> 0 for free.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)  head_d = head_q + 1'b1;
    if (push_i) tail_d = tail_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == (INDEX_W+1)'(SIZE));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bpred_update_queue.sv
// Buffers PHT/BTB updates from executed branches until the predictor RAMs
// have a free write slot, then retires them in FIFO order.
// Ports: clk, rst (sync, active-high), brResult (executed-branch result),
// portBusy (RAMs unavailable this cycle), full, PHT write port
// (phtWE/phtWA/phtWV), BTB write port (btbWE/btbWA/btbWV), dropCount
// (saturating count of results lost because the queue was full).
module bpred_update_queue
  import bpred_update_queue_pkg::*;
#(
  parameter int QUEUE_SIZE = BTB_QUEUE_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  BranchResult  brResult,
  input  logic         portBusy,
  output logic         full,
  output logic         phtWE,
  output PHT_IndexPath phtWA,
  output PHT_EntryPath phtWV,
  output logic         btbWE,
  output BTB_IndexPath btbWA,
  output BTB_Entry     btbWV,
  output logic [15:0]  dropCount
);

  localparam int IW = $clog2(QUEUE_SIZE);

  BranchUpdateQueueEntry queue_q [QUEUE_SIZE];
  BranchUpdateQueueEntry newEntry, headEntry;

  logic [IW-1:0] head, tail;
  logic [IW:0]   count;
  logic          empty, qualify, push, pop, drop;
  logic [15:0]   dropCount_q, dropCount_d;

  // Only branches that change predictor state are worth a slot.
  assign qualify = brResult.valid && (brResult.isCondBr || brResult.execTaken);
  // full reflects the count before the edge, so a push while full is lost
  // even if the head pops in the same cycle.
  assign push    = qualify && !full;
  assign drop    = qualify && full;
  assign pop     = !empty && !portBusy;

  circular_queue_pointer #(
    .SIZE    (QUEUE_SIZE),
    .INDEX_W (IW)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    newEntry                = '0;
    newEntry.phtWE          = brResult.isCondBr;
    newEntry.phtWA          = ToPHT_Index(brResult.brAddr, brResult.globalHistory);
    newEntry.phtWV          = SaturatePHT(brResult.phtPrevValue, brResult.execTaken);
    newEntry.btbWE          = brResult.execTaken;
    newEntry.btbWA          = ToBTB_Index(brResult.brAddr);
    newEntry.btbWV.valid    = 1'b1;
    newEntry.btbWV.tag      = ToBTB_Tag(brResult.brAddr);
    newEntry.btbWV.data     = ToBTB_Addr(brResult.nextAddr);
    newEntry.btbWV.isCondBr = brResult.isCondBr;
  end

  // Storage needs no reset: a cleared count makes stale slots unreachable.
  always_ff @(posedge clk) begin
    if (push && !rst) queue_q[tail] <= newEntry;
  end

  always_comb begin
    dropCount_d = dropCount_q;
    if (drop && dropCount_q != 16'hFFFF) dropCount_d = dropCount_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) dropCount_q <= '0;
    else     dropCount_q <= dropCount_d;
  end

  // Head is read straight from storage; a freshly pushed entry is only
  // visible after the edge that stored it, so there is no bypass path.
  assign headEntry = queue_q[head];
  assign phtWE     = pop && headEntry.phtWE;
  assign phtWA     = headEntry.phtWA;
  assign phtWV     = headEntry.phtWV;
  assign btbWE     = pop && headEntry.btbWE;
  assign btbWA     = headEntry.btbWA;
  assign btbWV     = headEntry.btbWV;
  assign dropCount = dropCount_q;

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_bpred_update_queue.sv
module tb_bpred_update_queue;
  import bpred_update_queue_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  BranchResult  brResult;
  logic         portBusy;
  logic         full;
  logic         phtWE;
  PHT_IndexPath phtWA;
  PHT_EntryPath phtWV;
  logic         btbWE;
  BTB_IndexPath btbWA;
  BTB_Entry     btbWV;
  logic [15:0]  dropCount;

  always #5 clk = ~clk;

  bpred_update_queue #(.QUEUE_SIZE(32)) dut (
    .clk(clk), .rst(rst), .brResult(brResult), .portBusy(portBusy),
    .full(full), .phtWE(phtWE), .phtWA(phtWA), .phtWV(phtWV),
    .btbWE(btbWE), .btbWA(btbWA), .btbWV(btbWV), .dropCount(dropCount)
  );

  typedef struct {
    bit          pwe;
    int unsigned pwa;
    int unsigned pwv;
    bit          bwe;
    int unsigned bwa;
    int unsigned btag;
    int unsigned bdata;
    bit          bcond;
  } exp_t;

  exp_t        mq[$];
  int unsigned mdrop  = 0;
  bit          mvalid = 0;
  int          writes = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference entry built from address arithmetic rather than bit slicing.
  function automatic exp_t mk(BranchResult b);
    exp_t e;
    int   p;
    p       = int'(b.phtPrevValue);
    e.pwe   = b.isCondBr;
    e.pwa   = ((b.brAddr / 4) % 1024) ^ (int'(b.globalHistory) % 1024);
    e.pwv   = b.execTaken ? ((p >= 3) ? 3 : p + 1) : ((p == 0) ? 0 : p - 1);
    e.bwe   = b.execTaken;
    e.bwa   = (b.brAddr / 4) % 512;
    e.btag  = (b.brAddr / 2048) % 64;
    e.bdata = b.nextAddr / 4;
    e.bcond = b.isCondBr;
    return e;
  endfunction

  task automatic drive(bit v, bit cond, bit tk, int unsigned addr, int unsigned hist,
                       int unsigned prev, int unsigned nxt, bit busy);
    brResult.valid         = v;
    brResult.isCondBr      = cond;
    brResult.execTaken     = tk;
    brResult.brAddr        = addr;
    brResult.globalHistory = BranchGlobalHistoryPath'(hist);
    brResult.phtPrevValue  = PHT_EntryPath'(prev);
    brResult.nextAddr      = nxt;
    portBusy               = busy;
  endtask

  task automatic drive_rand_qual(bit busy);
    bit c, t;
    c = 1'($urandom_range(0, 1));
    t = c ? 1'($urandom_range(0, 1)) : 1'b1;
    drive(1, c, t, $urandom, $urandom_range(0, 4095), $urandom_range(0, 3), $urandom, busy);
  endtask

  task automatic idle(bit busy);
    drive(0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance it.
  task automatic cycle();
    bit fb, q;
    @(negedge clk);
    if (mvalid) begin
      chk("full", full, mq.size() == 32);
      chk("dropCount", dropCount, mdrop);
      if (mq.size() > 0 && !portBusy) begin
        chk("phtWE", phtWE, mq[0].pwe);
        if (mq[0].pwe) begin
          chk("phtWA", phtWA, mq[0].pwa);
          chk("phtWV", phtWV, mq[0].pwv);
        end
        chk("btbWE", btbWE, mq[0].bwe);
        if (mq[0].bwe) begin
          chk("btbWA", btbWA, mq[0].bwa);
          chk("btbWV", {btbWV.valid, btbWV.tag, btbWV.data, btbWV.isCondBr},
              {1'b1, 6'(mq[0].btag), 30'(mq[0].bdata), mq[0].bcond});
        end
      end else begin
        chk("phtWE_idle", phtWE, 0);
        chk("btbWE_idle", btbWE, 0);
      end
    end
    if (phtWE === 1'b1 || btbWE === 1'b1) writes++;
    if (rst) begin
      mq.delete();
      mdrop  = 0;
      mvalid = 1;
    end else if (mvalid) begin
      fb = (mq.size() == 32);
      q  = brResult.valid && (brResult.isCondBr || brResult.execTaken);
      if (mq.size() > 0 && !portBusy) void'(mq.pop_front());
      if (q && !fb) mq.push_back(mk(brResult));
      else if (q && fb && mdrop != 65535) mdrop++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle(0);
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_full", full, 0);
    chk("rst_phtWE", phtWE, 0);
    chk("rst_btbWE", btbWE, 0);
    chk("rst_drop", dropCount, 0);

    // Conditional taken, prev=2: written the cycle after enqueue.
    drive(1, 1, 1, 32'h1000, 0, 2, 32'h2000, 0);
    cycle();
    idle(0); #1;
    chk("ct_phtWE", phtWE, 1);
    chk("ct_phtWA", phtWA, 0);
    chk("ct_phtWV", phtWV, 3);
    chk("ct_btbWE", btbWE, 1);
    chk("ct_btbData", btbWV.data, 30'h800);
    cycle();
    cycle();

    // Conditional not-taken saturating low.
    drive(1, 1, 0, 32'h2004, 3, 0, 0, 0);
    cycle();
    idle(0); #1;
    chk("cnt_phtWE", phtWE, 1);
    chk("cnt_phtWV", phtWV, 0);
    chk("cnt_btbWE", btbWE, 0);
    cycle();

    // Conditional taken saturating high.
    drive(1, 1, 1, 32'h3008, 5, 3, 32'h4000, 0);
    cycle();
    idle(0); #1;
    chk("csat_phtWV", phtWV, 3);
    cycle();

    // Unconditional not-taken: no entry, no drop.
    drive(1, 0, 0, 32'h5000, 0, 1, 0, 0);
    cycle();
    idle(0); #1;
    chk("unc_phtWE", phtWE, 0);
    chk("unc_btbWE", btbWE, 0);
    chk("unc_drop", dropCount, 0);
    cycle();

    // Busy for 40 cycles, 34 qualifying results; idle cycles carry
    // non-qualifying valid results that must not count as drops.
    for (int i = 0; i < 34; i++) begin drive_rand_qual(1); cycle(); end
    for (int i = 0; i < 6; i++) begin drive(1, 0, 0, $urandom, 0, 0, 0, 1); cycle(); end
    chk("fill_full", full, 1);
    chk("fill_drop", dropCount, 2);
    writes = 0;
    idle(0);
    cycle();
    chk("fill_full_after_pop", full, 0);
    for (int i = 0; i < 34; i++) cycle();
    chk("fill_writes", writes, 32);

    // Full queue, push and pop together: push is lost.
    for (int i = 0; i < 32; i++) begin drive_rand_qual(1); cycle(); end
    drive_rand_qual(0);
    cycle();
    chk("pp_drop", dropCount, 3);
    writes = 0;
    idle(0);
    for (int i = 0; i < 35; i++) cycle();
    chk("pp_writes", writes, 31);

    // Reset with entries queued and a qualifying result present.
    for (int i = 0; i < 5; i++) begin drive_rand_qual(1); cycle(); end
    rst = 1'b1;
    drive_rand_qual(1);
    cycle();
    rst = 1'b0;
    writes = 0;
    idle(0);
    for (int i = 0; i < 5; i++) cycle();
    chk("rstq_writes", writes, 0);
    chk("rstq_drop", dropCount, 0);
    for (int i = 0; i < 33; i++) begin drive_rand_qual(0); cycle(); end
    idle(0);
    for (int i = 0; i < 3; i++) cycle();
    chk("wrap_writes", writes, 33);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0) drive_rand_qual(1'($urandom_range(0, 1) & ($urandom_range(0, 3) != 0)));
      else drive(1'($urandom_range(0, 1)), 0, 0, $urandom, 0, 0, 0, 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpred_update_queue.md
BPRED_UPDATE_QUEUE -- requirements
Module: bpred_update_queue

Interface
REQ-001 The block SHALL have parameter QUEUE_SIZE, default 32 (BTB_QUEUE_SIZE), meaning queue depth, power of two.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port brResult, input, BranchResult: executed-branch result, qualified by brResult.valid.
REQ-005 The block SHALL have port portBusy, input, 1 bit: predictor RAMs busy this cycle, no write allowed.
REQ-006 The block SHALL have port full, output, 1 bit: count == QUEUE_SIZE.
REQ-007 The block SHALL have ports phtWE (output, 1), phtWA (output, PHT_IndexPath) and phtWV (output, PHT_EntryPath): PHT write port.
REQ-008 The block SHALL have ports btbWE (output, 1), btbWA (output, BTB_IndexPath) and btbWV (output, BTB_Entry): BTB write port.
REQ-009 The block SHALL have port dropCount, output, 16 bits: saturating count of results lost to a full queue.

Function
REQ-010 Enqueue condition: brResult.valid && !full && (isCondBr || execTaken); a result meeting none of these SHALL produce no entry and no drop.
REQ-011 PHT part of an entry: enabled iff isCondBr.
REQ-012 PHT index SHALL be brAddr[PHT_ENTRY_NUM_BIT_WIDTH+INSN_ADDR_BIT_WIDTH-1:INSN_ADDR_BIT_WIDTH] XOR globalHistory, with history zero-extended or truncated to PHT width.
REQ-013 PHT value SHALL be phtPrevValue+1 if execTaken, else phtPrevValue-1, saturating at 0 and PHT_ENTRY_MAX.
REQ-014 BTB part of an entry: enabled iff execTaken.
REQ-015 BTB index SHALL be ToBTB_Index(brAddr); the BTB value SHALL be {valid=1, tag=ToBTB_Tag(brAddr), data=ToBTB_Addr(nextAddr), isCondBr}.
REQ-016 Drain: when count>0 and !portBusy, the head entry SHALL drive the write ports the same cycle, with phtWE/btbWE equal to the entry enables, and SHALL be popped at the clock edge.
REQ-017 When count==0 or portBusy, phtWE and btbWE SHALL both be 0; WA/WV are don't-care.
REQ-018 Latency: a result enqueued at edge N SHALL be writable no earlier than the cycle following edge N; there is no input-to-write bypass.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, with both pointers advancing.
REQ-020 full SHALL be evaluated on the count before the edge; a push while full is dropped even if a pop occurs the same cycle.
REQ-021 A valid result meeting REQ-010 but arriving while full SHALL increment dropCount, which holds at 16'hFFFF.
REQ-022 Head and tail pointers SHALL be log2(QUEUE_SIZE) bits and wrap naturally from QUEUE_SIZE-1 to 0; count SHALL be log2(QUEUE_SIZE)+1 bits.
REQ-023 Entries SHALL leave the queue in FIFO order; order between PHT and BTB updates of different branches SHALL be preserved.

Reset
REQ-024 On rst at a clock edge: head=0, tail=0, count=0, dropCount=0; full=0, phtWE=0 and btbWE=0 in the following cycle.
REQ-025 Reset mid-operation SHALL discard all queued entries; no write SHALL be issued for them afterwards.
REQ-026 A brResult present during a reset cycle SHALL be ignored.

Structure
REQ-027 Typedef BranchUpdateQueueEntry {phtWE, PHT_IndexPath, PHT_EntryPath, btbWE, BTB_IndexPath, BTB_Entry} SHALL be added to FetchUnitTypes.
REQ-028 Functions ToPHT_Index(PC_Path, BranchGlobalHistoryPath) and SaturatePHT(PHT_EntryPath, logic) SHALL be added to FetchUnitTypes.
REQ-029 Queue storage SHALL be a register array of BranchUpdateQueueEntry inside the module.
REQ-030 Head/tail/count handling SHALL be a single sub-module, circular_queue_pointer.

Verification
REQ-031 The bench SHALL cover: cond taken, brAddr=0x1000, hist=0, prev=2, portBusy=0 -> next cycle phtWE=1, phtWV=3, btbWE=1, btbWV.data=ToBTB_Addr(nextAddr), count back to 0.
REQ-032 The bench SHALL cover: cond not-taken prev=0 -> phtWV=0, btbWE=0; cond taken prev=3 -> phtWV=3.
REQ-033 The bench SHALL cover: unconditional not-taken (isCondBr=0, execTaken=0) -> no entry, count unchanged, dropCount unchanged.
REQ-034 The bench SHALL cover: portBusy=1 for 40 cycles with 34 qualifying results -> full asserted after 32, dropCount=2; then portBusy=0 -> 32 writes in FIFO order, full deasserts after the first pop.
REQ-035 The bench SHALL cover: full queue with push and pop in the same cycle -> push dropped, count=31, dropCount+1.
REQ-036 The bench SHALL cover: 5 entries queued, rst for 1 cycle -> count=0, no writes issued for the 5 entries, pointers resume from 0 with correct wrap after 33 push/pop pairs.
